// File: rtl/camera_cfg_pkg.sv
// camera_cfg_pkg: shared types and constants for the camera configuration sequencer.
package camera_cfg_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_BUSY_LO,
        S_ADVANCE,
        S_DELAY,
        S_DONE,
        S_ERROR
    } cfg_state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] reg_data;
    } cfg_entry_t;

    localparam logic [15:0] CFG_END            = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY          = 16'hFFF0;
    localparam logic [7:0]  DEFAULT_SLAVE_ADDR = 8'h42;
endpackage

// File: rtl/camera_config_rom.sv
// camera_config_rom: camera register write list, index -> {reg, data}; CFG_DELAY marks a settle delay.
module camera_config_rom
    import camera_cfg_pkg::*;
#(
    parameter int NUM_REGS = 76
) (
    input  logic [7:0] i_index,
    output cfg_entry_t o_entry
);
    cfg_entry_t w_entry;

    always_comb begin
        case (i_index)
            8'd0:    w_entry = 16'h1280;
            8'd1:    w_entry = 16'h1101;
            8'd2:    w_entry = CFG_DELAY;
            8'd3:    w_entry = 16'h1204;
            8'd4:    w_entry = 16'h0C00;
            8'd5:    w_entry = 16'h3E00;
            8'd6:    w_entry = 16'h8C00;
            8'd7:    w_entry = 16'h0400;
            8'd8:    w_entry = 16'h4010;
            8'd9:    w_entry = 16'h3A04;
            8'd10:   w_entry = 16'h1438;
            8'd11:   w_entry = 16'h4FB3;
            8'd12:   w_entry = 16'h50B3;
            8'd13:   w_entry = 16'h5100;
            8'd14:   w_entry = 16'h523D;
            8'd15:   w_entry = 16'h53A7;
            8'd16:   w_entry = 16'h54E4;
            8'd17:   w_entry = 16'h589E;
            8'd18:   w_entry = 16'h3DC0;
            8'd19:   w_entry = 16'h1714;
            8'd20:   w_entry = 16'h1802;
            8'd21:   w_entry = 16'h3280;
            8'd22:   w_entry = 16'h1903;
            8'd23:   w_entry = 16'h1A7B;
            8'd24:   w_entry = 16'h030A;
            8'd25:   w_entry = 16'h0F41;
            8'd26:   w_entry = 16'h1E00;
            8'd27:   w_entry = 16'h330B;
            8'd28:   w_entry = 16'h3C78;
            8'd29:   w_entry = 16'h6900;
            8'd30:   w_entry = 16'h7400;
            8'd31:   w_entry = 16'hB084;
            8'd32:   w_entry = 16'hB10C;
            8'd33:   w_entry = 16'hB20E;
            8'd34:   w_entry = 16'hB380;
            8'd35:   w_entry = 16'h7A20;
            8'd36:   w_entry = 16'h7B10;
            8'd37:   w_entry = 16'h7C1E;
            8'd38:   w_entry = 16'h7D35;
            8'd39:   w_entry = 16'h7E5A;
            8'd40:   w_entry = 16'h7F69;
            8'd41:   w_entry = 16'h8076;
            8'd42:   w_entry = 16'h8180;
            8'd43:   w_entry = 16'h8288;
            8'd44:   w_entry = 16'h838F;
            8'd45:   w_entry = 16'h8496;
            8'd46:   w_entry = 16'h85A3;
            8'd47:   w_entry = 16'h86AF;
            8'd48:   w_entry = 16'h87C4;
            8'd49:   w_entry = 16'h88D7;
            8'd50:   w_entry = 16'h89E8;
            8'd51:   w_entry = 16'h13E0;
            8'd52:   w_entry = 16'h0000;
            8'd53:   w_entry = 16'h1000;
            8'd54:   w_entry = 16'h0D40;
            8'd55:   w_entry = 16'h1418;
            8'd56:   w_entry = 16'hA505;
            8'd57:   w_entry = 16'hAB07;
            8'd58:   w_entry = 16'h2495;
            8'd59:   w_entry = 16'h2533;
            8'd60:   w_entry = 16'h26E3;
            8'd61:   w_entry = 16'h9F78;
            8'd62:   w_entry = 16'hA068;
            8'd63:   w_entry = 16'hA103;
            8'd64:   w_entry = 16'hA6D8;
            8'd65:   w_entry = 16'hA7D8;
            8'd66:   w_entry = 16'hA8F0;
            8'd67:   w_entry = 16'hA990;
            8'd68:   w_entry = 16'hAA94;
            8'd69:   w_entry = 16'h13E5;
            8'd70:   w_entry = 16'h6B0A;
            8'd71:   w_entry = 16'h2A00;
            8'd72:   w_entry = 16'h2B00;
            8'd73:   w_entry = 16'h9200;
            8'd74:   w_entry = 16'h9300;
            8'd75:   w_entry = 16'h7135;
            default: w_entry = CFG_END;
        endcase
    end

    assign o_entry = (int'(i_index) >= NUM_REGS) ? CFG_END : w_entry;
endmodule

// File: rtl/camera_config_sequencer.sv
// camera_config_sequencer: walks the camera register table and hands each write to the SCCB controller.
// Optional per-handshake watchdog is built when CAM_CFG_WATCHDOG_EN is defined.
module camera_config_sequencer
    import camera_cfg_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR     = DEFAULT_SLAVE_ADDR,
    parameter int         NUM_REGS       = 76,
    parameter int         DELAY_CYCLES   = 1_000_000,
    parameter int         TIMEOUT_CYCLES = 2**21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    input  logic       sccb_busy,
    output logic       sccb_start,
    output logic [7:0] sccb_address,
    output logic [7:0] sccb_command,
    output logic [7:0] sccb_data,
    output logic       sccb_increment_done,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic [7:0] cfg_index
);
    localparam int DW = $clog2(DELAY_CYCLES + 1);

    if (NUM_REGS > 255 || DELAY_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("camera_config_sequencer: NUM_REGS must be <= 255 and cycle counts >= 1");
    end

    cfg_state_t    r_state, w_next;
    cfg_entry_t    w_entry;
    logic [7:0]    r_index, r_command, r_data;
    logic [DW-1:0] r_dcnt;
    logic          r_start, r_inc_done, r_busy, r_done;
    logic          w_restart, w_handshake, w_timeout;

    camera_config_rom #(.NUM_REGS(NUM_REGS)) u_rom (
        .i_index (r_index),
        .o_entry (w_entry)
    );

    assign w_restart   = (r_state inside {S_IDLE, S_DONE, S_ERROR}) && cfg_start;
    assign w_handshake = (r_state == S_ISSUE) || (r_state == S_WAIT_BUSY_LO);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: w_next = cfg_start ? S_FETCH : r_state;
            S_FETCH:        w_next = (w_entry == CFG_END) ? S_DONE : (w_entry == CFG_DELAY) ? S_DELAY : S_ISSUE;
            S_ISSUE:        w_next = sccb_busy ? S_WAIT_BUSY_LO : S_ISSUE;
            S_WAIT_BUSY_LO: w_next = sccb_busy ? S_WAIT_BUSY_LO : S_ADVANCE;
            S_ADVANCE:      w_next = S_FETCH;
            S_DELAY:        w_next = (r_dcnt == DW'(DELAY_CYCLES - 1)) ? S_ADVANCE : S_DELAY;
            default:        w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERROR;
    end

`ifdef CAM_CFG_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wdog;
    logic          r_error;

    assign w_timeout = w_handshake && (r_wdog == TW'(TIMEOUT_CYCLES - 1));
    assign cfg_error = r_error;

    // Restarts on every state change so each handshake wait gets the full budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog  <= '0;
            r_error <= 1'b0;
        end else begin
            r_wdog  <= (w_next != r_state || !w_handshake) ? '0 : r_wdog + 1'b1;
            r_error <= !w_restart && (r_error || w_next == S_ERROR);
        end
    end
`else
    assign w_timeout = 1'b0;
    assign cfg_error = 1'b0;
`endif

    // Outputs are registered from the next state so they change together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_index    <= 8'd0;
            r_command  <= 8'd0;
            r_data     <= 8'd0;
            r_start    <= 1'b0;
            r_inc_done <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dcnt     <= '0;
        end else begin
            r_state    <= w_next;
            r_index    <= w_restart ? 8'd0 : (r_state == S_ADVANCE) ? r_index + 8'd1 : r_index;
            r_command  <= (r_state == S_FETCH && w_next == S_ISSUE) ? w_entry.reg_addr : r_command;
            r_data     <= (r_state == S_FETCH && w_next == S_ISSUE) ? w_entry.reg_data : r_data;
            r_start    <= (w_next == S_ISSUE);
            r_inc_done <= (w_next == S_ISSUE) ? 1'b0 : (w_next inside {S_ADVANCE, S_IDLE, S_DONE, S_ERROR}) ? 1'b1 : r_inc_done;
            r_busy     <= !(w_next inside {S_IDLE, S_DONE, S_ERROR});
            r_done     <= !w_restart && (r_done || w_next == S_DONE);
            r_dcnt     <= (r_state == S_DELAY) ? r_dcnt + 1'b1 : '0;
        end
    end

    assign sccb_start          = r_start;
    assign sccb_address        = SLAVE_ADDR;
    assign sccb_command        = r_command;
    assign sccb_data           = r_data;
    assign sccb_increment_done = r_inc_done;
    assign cfg_busy            = r_busy;
    assign cfg_done            = r_done;
    assign cfg_index           = r_index;
endmodule
